// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and constants for the six-position multiplexed
//                7-segment scan driver: segment codes (active-low, ordered
//                {g,f,e,d,c,b,a}), the BCD value record, and the scan state.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam int NUM_POS    = 6;   // sign + five digits
    localparam int NUM_DIGITS = 5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;

    // Element k is the pattern for digit k (listed 9 down to 0).
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Sign flag plus five BCD digits; digit[0] is the units digit.
    typedef struct packed {
        logic                        negative;
        logic [NUM_DIGITS-1:0][3:0]  digit;
    } bcd_value_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational BCD to active-low 7-segment decoder.
//                Codes 10..15 decode to 'E'.
//  Ports       : i_code  [3:0]  BCD digit
//                o_seg_n [6:0]  active-low segments {g,f,e,d,c,b,a}
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_E;
        if (i_code <= 4'd9) begin
            o_seg_n = SEG_DIGIT[i_code];
        end
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Six-position common-anode multiplexed 7-segment driver.
//                Position 5 shows the sign, positions 4..0 the BCD digits.
//                New values are staged and only reach the display at a frame
//                boundary; each position slot starts with a blanking gap.
//  Ports       : clk, rst_n           clock / async active-low reset
//                update               one-cycle strobe sampling the inputs
//                negative, bcd_digit* sign and digits from the converter
//                an_n  [5:0]          active-low anodes, bit k = position k
//                seg_n [6:0]          active-low segments {g,f,e,d,c,b,a}
//                pending              staged value awaiting frame boundary
//                frame_start          pulse on first SHOW cycle of position 0
//  Options     : LZB_EN  enables leading-zero blanking of digits 4..1
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update,
    input  logic       negative,
    input  logic [3:0] bcd_digit0,
    input  logic [3:0] bcd_digit1,
    input  logic [3:0] bcd_digit2,
    input  logic [3:0] bcd_digit3,
    input  logic [3:0] bcd_digit4,
    output logic [5:0] an_n,
    output logic [6:0] seg_n,
    output logic       pending,
    output logic       frame_start
);

    localparam int                CNT_W       = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  c_dead_last = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0]  c_slot_last = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]        c_last_pos  = 3'(NUM_POS - 1);

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    scan_state_t      state_q,      state_d;
    logic [2:0]       idx_q,        idx_d;
    logic             started_q,    started_d;
    bcd_value_t       stage_q,      stage_d;
    bcd_value_t       disp_q,       disp_d;
    logic             pending_q,    pending_d;
    logic [5:0]       an_n_q,       an_n_d;
    logic [6:0]       seg_n_q,      seg_n_d;
    logic             frame_start_q, frame_start_d;

    bcd_value_t       in_val;
    logic             boundary;
    logic [3:0]       pos_code;
    logic [6:0]       dec_seg_n;
    logic [4:0]       lead_zero;

    // ------------------------------------------------------------------
    // Scan sequencing and double buffering
    // ------------------------------------------------------------------
    always_comb begin
        in_val.negative = negative;
        in_val.digit    = {bcd_digit4, bcd_digit3, bcd_digit2, bcd_digit1, bcd_digit0};

        cnt_d     = (cnt_q == c_slot_last) ? '0 : cnt_q + CNT_W'(1);
        state_d   = state_q;
        idx_d     = idx_q;
        started_d = started_q;
        boundary  = 1'b0;

        if (state_q == BLANK) begin
            if (cnt_q == c_dead_last) begin
                state_d   = SHOW;
                started_d = 1'b1;
                // The very first slot after reset must land on position 0.
                if (started_q) begin
                    idx_d = (idx_q == c_last_pos) ? 3'd0 : idx_q + 3'd1;
                end
                boundary = (idx_d == 3'd0);
            end
        end else begin
            if (cnt_q == c_slot_last) begin
                state_d = BLANK;
            end
        end

        stage_d   = stage_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (update) begin
            stage_d   = in_val;
            pending_d = 1'b1;
        end
        // An update coinciding with the boundary is newer than anything
        // staged, so it goes straight to the display.
        if (boundary) begin
            if (update) begin
                disp_d = in_val;
            end else if (pending_q) begin
                disp_d = stage_q;
            end
            pending_d = 1'b0;
        end

        frame_start_d = boundary;
    end

    // ------------------------------------------------------------------
    // Leading-zero detection: lead_zero[k] set when digits 4..k are all 0
    // ------------------------------------------------------------------
`ifdef LZB_EN
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero     = all_zero & (disp_d.digit[k] == 4'd0);
            lead_zero[k] = all_zero;
        end
    end
`else
    always_comb begin
        lead_zero = '0;
    end
`endif

    // ------------------------------------------------------------------
    // Output decode, evaluated on next-state values so the registered
    // outputs line up with the registered state.
    // ------------------------------------------------------------------
    always_comb begin
        pos_code = 4'd0;
        if (idx_d < c_last_pos) begin
            pos_code = disp_d.digit[idx_d];
        end
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .i_code  (pos_code),
        .o_seg_n (dec_seg_n)
    );

    always_comb begin
        an_n_d  = 6'h3F;
        seg_n_d = SEG_BLANK;
        if (state_d == SHOW) begin
            an_n_d = ~(6'b000001 << idx_d);
            if (idx_d == c_last_pos) begin
                seg_n_d = disp_d.negative ? SEG_MINUS : SEG_BLANK;
            end else if (lead_zero[idx_d]) begin
                seg_n_d = SEG_BLANK;
            end else begin
                seg_n_d = dec_seg_n;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            state_q       <= BLANK;
            idx_q         <= 3'd0;
            started_q     <= 1'b0;
            stage_q       <= '0;
            disp_q        <= '0;
            pending_q     <= 1'b0;
            an_n_q        <= 6'h3F;
            seg_n_q       <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            started_q     <= started_d;
            stage_q       <= stage_d;
            disp_q        <= disp_d;
            pending_q     <= pending_d;
            an_n_q        <= an_n_d;
            seg_n_q       <= seg_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an_n        = an_n_q;
    assign seg_n       = seg_n_q;
    assign pending     = pending_q;
    assign frame_start = frame_start_q;

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Directed self-checking bench for seg7_scan_driver with
//                CLK_DIV=8, DEAD_CYC=2 (48-cycle frame). Expected segment
//                patterns are hand-derived; LZB_EN selects the blanked set.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int CLK_DIV  = 8;
    localparam int DEAD_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       update = 1'b0;
    logic       negative = 1'b0;
    logic [3:0] bcd_digit0 = 4'd0;
    logic [3:0] bcd_digit1 = 4'd0;
    logic [3:0] bcd_digit2 = 4'd0;
    logic [3:0] bcd_digit3 = 4'd0;
    logic [3:0] bcd_digit4 = 4'd0;
    logic [5:0] an_n;
    logic [6:0] seg_n;
    logic       pending;
    logic       frame_start;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [6:0] cap_seg [0:5];
    logic [5:0] cap_an  [0:5];
    logic       cap_pending;
    logic       fs_found;

    seg7_scan_driver #(
        .CLK_DIV  (CLK_DIV),
        .DEAD_CYC (DEAD_CYC)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .update      (update),
        .negative    (negative),
        .bcd_digit0  (bcd_digit0),
        .bcd_digit1  (bcd_digit1),
        .bcd_digit2  (bcd_digit2),
        .bcd_digit3  (bcd_digit3),
        .bcd_digit4  (bcd_digit4),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .pending     (pending),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives the inputs at a falling edge and pulses update for one cycle.
    task automatic load_value(input logic neg, input logic [3:0] d4, input logic [3:0] d3,
                              input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
        negative   = neg;
        bcd_digit4 = d4;
        bcd_digit3 = d3;
        bcd_digit2 = d2;
        bcd_digit1 = d1;
        bcd_digit0 = d0;
        update     = 1'b1;
        @(negedge clk);
        update     = 1'b0;
    endtask

    task automatic wait_fs();
        fs_found = 1'b0;
        for (int i = 0; i < 120 && !fs_found; i++) begin
            @(negedge clk);
            if (frame_start) fs_found = 1'b1;
        end
        check_value("frame_start_seen", 32'(fs_found), 32'd1);
    endtask

    // Called on the falling edge where frame_start is high; samples each
    // position in the middle of its SHOW window.
    task automatic sample_frame();
        cap_pending = pending;
        for (int k = 0; k < 6; k++) begin
            repeat ((k == 0) ? 3 : 8) @(negedge clk);
            cap_seg[k] = seg_n;
            cap_an[k]  = an_n;
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                               input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] exp_seg [0:5];
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2;
        exp_seg[3] = e3; exp_seg[4] = e4; exp_seg[5] = e5;
        for (int k = 0; k < 6; k++) begin
            check_value($sformatf("%s_pos%0d", tag, k), 32'(cap_seg[k]), 32'(exp_seg[k]));
        end
    endtask

    initial begin
        int period;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_value("rst_an_n",        32'(an_n),        32'h3F);
        check_value("rst_seg_n",       32'(seg_n),       32'h7F);
        check_value("rst_pending",     32'(pending),     32'd0);
        check_value("rst_frame_start", 32'(frame_start), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check_value("blank_after_rst", 32'(an_n), 32'h3F);
        @(negedge clk);
        check_value("first_show_an",   32'(an_n),        32'h3E);
        check_value("first_show_fs",   32'(frame_start), 32'd1);
        check_value("first_show_seg",  32'(seg_n),       32'h40);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            check_value($sformatf("show_len_%0d", i), 32'(an_n), 32'h3E);
        end
        @(negedge clk);
        check_value("blank_after_show", 32'(an_n), 32'h3F);

        period = 6;
        fs_found = 1'b0;
        while (!fs_found && period < 200) begin
            @(negedge clk);
            period++;
            if (frame_start) fs_found = 1'b1;
        end
        check_value("frame_period", 32'(period), 32'd48);

        // ---------------- -32768 staged mid-frame ----------------
        repeat (4) @(negedge clk);
        load_value(1'b1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd8);
        check_value("pending_set",   32'(pending), 32'd1);
        check_value("no_early_show", 32'(seg_n),   32'h40);
        wait_fs();
        sample_frame();
        check_value("pending_cleared", 32'(cap_pending), 32'd0);
        check_frame("m32768", 7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00);
        check_value("an_pos3", 32'(cap_an[3]), 32'h37);
        check_value("an_pos5", 32'(cap_an[5]), 32'h1F);

        // ---------------- last write wins ----------------
        wait_fs();
        repeat (5) @(negedge clk);
        load_value(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        repeat (5) @(negedge clk);
        load_value(1'b0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
        wait_fs();
        sample_frame();
`ifdef LZB_EN
        check_frame("v00042", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24);
`else
        check_frame("v00042", 7'h7F, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24);
`endif

        // ---------------- update on the boundary cycle, code 0xC ----------------
        wait_fs();
        repeat (47) @(negedge clk);
        load_value(1'b0, 4'd0, 4'd0, 4'hC, 4'd0, 4'd5);
        check_value("coincident_fs", 32'(frame_start), 32'd1);
        sample_frame();
        check_value("coincident_pending",  32'(cap_pending), 32'd0);
        check_value("coincident_pending2", 32'(pending),     32'd0);
`ifdef LZB_EN
        check_frame("v00C05", 7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h40, 7'h12);
`else
        check_frame("v00C05", 7'h7F, 7'h40, 7'h40, 7'h06, 7'h40, 7'h12);
`endif

        // ---------------- async reset during position 3 ----------------
        wait_fs();
        repeat (2) @(negedge clk);
        load_value(1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        repeat (24) @(negedge clk);
        check_value("pre_rst_an",      32'(an_n),    32'h37);
        check_value("pre_rst_pending", 32'(pending), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_value("async_rst_an",      32'(an_n),        32'h3F);
        check_value("async_rst_seg",     32'(seg_n),       32'h7F);
        check_value("async_rst_pending", 32'(pending),     32'd0);
        check_value("async_rst_fs",      32'(frame_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_value("post_rst_an", 32'(an_n), 32'h3E);
        sample_frame();
        check_value("post_rst_pending", 32'(cap_pending), 32'd0);
        check_value("post_rst_pos0",    32'(cap_seg[0]),  32'h40);
        check_value("post_rst_pos5",    32'(cap_seg[5]),  32'h7F);
`ifdef LZB_EN
        check_value("post_rst_pos2",    32'(cap_seg[2]),  32'h7F);
`else
        check_value("post_rst_pos2",    32'(cap_seg[2]),  32'h40);
`endif

        // ---------------- negative zero, then positive zero ----------------
        wait_fs();
        repeat (3) @(negedge clk);
        load_value(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        wait_fs();
        sample_frame();
`ifdef LZB_EN
        check_frame("neg_zero", 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
`else
        check_frame("neg_zero", 7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
`endif

        wait_fs();
        repeat (3) @(negedge clk);
        load_value(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        wait_fs();
        sample_frame();
        check_value("pos_zero_pos5", 32'(cap_seg[5]), 32'h7F);
        check_value("pos_zero_pos0", 32'(cap_seg[0]), 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_seg7_scan_driver
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the 16-bit binary-to-BCD converter.
- Takes its sign flag and five BCD digits and drives a six-position, common-anode, multiplexed 7-segment display.
  - Position 5 is the sign.
  - Positions 4..0 are the digits, most significant first.
- Double-buffers the value so the display only changes at frame boundaries.
- Inserts a dead-time gap between positions to suppress ghosting.

Parameters:
- CLK_DIV, 50000: clock cycles per position slot (SHOW + BLANK). Must be >= 4.
- DEAD_CYC, 16: cycles per slot with all anodes off. Must satisfy 1 <= DEAD_CYC < CLK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- update  in  1  one-cycle strobe; samples negative and the digit inputs.
- negative  in  1  sign from the converter.
- bcd_digit0..bcd_digit4  in  4 each  BCD digits; digit0 is the units digit.
- an_n  out  6  active-low anode enables; bit k = position k.
- seg_n  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- pending  out  1  a staged value is waiting for the next frame boundary.
- frame_start  out  1  one-cycle pulse when position 0 becomes active.

Behaviour:
- **Reset (asynchronous, rst_n low):**
  - an_n=6'h3F, seg_n=7'h7F, pending=0, frame_start=0.
  - Staging and display registers cleared to 0 (positive zero).
  - Scan index=0, state=BLANK, prescaler=0.
- **Reset mid-operation:** outputs go to reset values immediately, independent of clk. After release, position 0 becomes active after DEAD_CYC cycles.
- **Prescaler and state machine.** The prescaler counts 0..CLK_DIV-1 and wraps.
  - BLANK: an_n=6'h3F, seg_n=7'h7F. Lasts DEAD_CYC cycles, then goes to SHOW.
  - On the BLANK->SHOW transition, index advances mod 6 (5 wraps to 0). Exception: the first transition after reset keeps index 0.
  - SHOW: an_n has only bit[index] low; seg_n is the registered decode of position index. Lasts CLK_DIV-DEAD_CYC cycles, then goes to BLANK.
  - One full frame = 6*CLK_DIV cycles.
- **Frame boundary:** the BLANK->SHOW transition with new index 0.
  - frame_start=1 on the first SHOW cycle of position 0.
  - If pending=1, the staging register is copied to the display register in the cycle before that first SHOW cycle; pending is cleared at the same time.
- **update handling:**
  - When update=1, inputs are captured into the staging register and pending=1 on the next edge.
  - A later update before the boundary overwrites the staged value (last write wins).
  - update in the same cycle as the boundary transfer: the new inputs go straight to the display register, bypassing staging, and pending ends at 0.
- **Decode (registered, one cycle latency from index/display change):**
  - Digits 0-9: seg_n = 40,79,24,30,19,12,02,78,00,10 (hex).
  - Digit codes 10-15 display 'E' = 06.
  - Sign position: '-' = 3F if negative, blank = 7F otherwise.
  - Negative zero is not suppressed; the '-' is shown.
- **Decimal point:** no dp output; segments only.

Optional Feature:
- Macro LZB_EN enables leading-zero blanking.
- Defined:
  - Digit k (k=4..1) shows blank (7F) when it and every higher digit are 0.
  - digit0 is never blanked.
  - The sign is unaffected and stays at position 5.
- Undefined: all five digits are always shown, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - segment constants: SEG_BLANK=7'h7F, SEG_MINUS=7'h3F, SEG_E=7'h06, and the digit table;
  - NUM_POS=6;
  - the state enum {BLANK, SHOW}.
- One combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-low out, E for codes above 9), instantiated once and fed by a mux on index.

Test Plan:
- Reset with CLK_DIV=8, DEAD_CYC=2 -> an_n=3F, seg_n=7F during reset. After release: 2 blank cycles, then an_n=3E for 6 cycles; frame_start pulses once per 48 cycles.
- update with negative=1, digits 4..0 = 3,2,7,6,8 (-32768) mid-frame -> pending=1. Next frame shows positions 5..0 = 3F,30,24,78,02,00; pending=0 at frame_start.
- Two updates in one frame (12345, then 00042) -> only 00042 displayed next frame.
  - LZB_EN defined: positions 4..2 show 7F, position 1 shows 19, position 0 shows 24.
  - LZB_EN undefined: 40,40,40,19,24.
- update coincident with the boundary transfer cycle -> the new value appears in that frame, pending stays 0.
- bcd_digit2=4'hC -> position 2 shows 06. All-zero positive value -> position 0 shows 40 in both builds.
- Assert rst_n low during SHOW of position 3 -> an_n=3F asynchronously; the display register clears to zero.
